lm_sm_sequencer: RTL
====================

LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001: Clk  input  1  single clock; all state updates on rising edge.
REQ-002: Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003: Start  input  1  decode-stage instruction is a valid LM/SM; sampled only in IDLE.
REQ-004: Is_Store  input  1  1 = SM (store multiple), 0 = LM (load multiple); latched with Start.
REQ-005: Reg_Mask  input  8  register mask from Instruction[7:0]; bit i selects Ri; latched with Start.
REQ-006: Base_Addr  input  16  RA contents (starting data-memory address); latched with Start.
REQ-007: Hold  input  1  downstream hazard stall; freezes ISSUE state for the cycle.
REQ-008: Busy  output  1  sequencer in ISSUE or DONE.
REQ-009: Stall_Fetch  output  1  hold PC and PR1 write (drives PC/IF-ID write-enable low).
REQ-010: Uop_Valid  output  1  micro-op presented this cycle.
REQ-011: Uop_Store  output  1  micro-op is a store (DM write), else a load (RF write).
REQ-012: Uop_Reg  output  3  register index of the micro-op.
REQ-013: Uop_Addr  output  16  data-memory address of the micro-op.
REQ-014: Uop_Last  output  1  current micro-op is the final one of the instruction.
REQ-015: Done  output  1  one-cycle completion pulse.

Function
REQ-016: States: IDLE, ISSUE, DONE; internal registers Mask_Rem[7:0], Addr_Reg[15:0], Store_Reg.
REQ-017: IDLE, Start=1, Reg_Mask!=0: latch Mask_Rem=Reg_Mask, Addr_Reg=Base_Addr, Store_Reg=Is_Store; next state ISSUE.
REQ-018: IDLE, Start=1, Reg_Mask==0: next state DONE; no micro-op is issued.
REQ-019: Start is ignored in ISSUE and DONE.
REQ-020: Uop_Valid = (state==ISSUE) & ~Hold, combinational from registered state.
REQ-021: Uop_Reg = index of the lowest set bit of Mask_Rem; issue order is ascending, R0 first.
REQ-022: Uop_Addr = Addr_Reg; Uop_Store = Store_Reg; Uop_Last = Uop_Valid & (exactly one bit set in Mask_Rem).
REQ-023: At each edge with Uop_Valid=1: clear the issued bit in Mask_Rem; Addr_Reg <= Addr_Reg+1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-024: At the edge where Uop_Last=1: next state DONE.
REQ-025: ISSUE with Hold=1: Mask_Rem, Addr_Reg and state are held; Uop_Valid=0.
REQ-026: DONE lasts exactly one cycle: Done=1, then IDLE unconditionally; Hold has no effect in IDLE or DONE.
REQ-027: Stall_Fetch = (state==ISSUE) | (state==IDLE & Start), and is deasserted in DONE so the following instruction advances.
REQ-028: Busy = (state!=IDLE).
REQ-029: Latency: Start at edge t; first Uop_Valid in the cycle after t; N set bits with no Hold gives Done N+1 cycles after t.
REQ-030: Uop_Reg, Uop_Addr and Uop_Store are don't-care when Uop_Valid=0, but SHALL be driven from registers without X.

Reset
REQ-031: Reset=1 at an edge forces state=IDLE, Mask_Rem=0, Addr_Reg=0 and Store_Reg=0, overriding Start and Hold.
REQ-032: After reset, all outputs are 0 (Stall_Fetch follows Start only). While Reset is high, Stall_Fetch is forced to 0.
REQ-033: Reset mid-ISSUE abandons remaining micro-ops with no Done pulse; Uop_Valid=0 from the next cycle.

Verification
REQ-034: LM, Reg_Mask=0x05, Base_Addr=0x0010, no Hold -> uops (R0,0x0010), (R2,0x0011, Uop_Last=1), Uop_Store=0; Done in the cycle after; Stall_Fetch high for 3 cycles including the Start cycle.
REQ-035: SM, Reg_Mask=0xFF, Base_Addr=0xFFFE -> 8 store uops R0..R7 at addresses 0xFFFE, 0xFFFF, 0x0000 .. 0x0005; Uop_Last only on R7.
REQ-036: Reg_Mask=0x00 with Start -> no Uop_Valid; Done=1 exactly one cycle after Start; Busy high for one cycle.
REQ-037: Reg_Mask=0x81 with Hold=1 for 2 cycles after the first uop -> R0 issues, then Uop_Valid=0 for 2 cycles with address held at base+1, then R7 issues at base+1.
REQ-038: Reset asserted after the 3rd uop of Reg_Mask=0xFF -> IDLE next cycle, no Done; a new Start with Reg_Mask=0x02 and Base_Addr=0x0100 issues (R1,0x0100).
REQ-039: Start asserted while Busy -> ignored; latched mask and address unchanged, and the sequence completes normally.

Source files
------------

// File: rtl/lm_sm_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : lm_sm_sequencer_if
// Description : Handshake bundle between the decode stage and the LM/SM
//               micro-op sequencer.
//               master : decode side. Drives start, is_store, reg_mask,
//                        base_addr and hold. Observes the sequencer status
//                        and the micro-op outputs.
//               slave  : sequencer side (lm_sm_sequencer).
// Revision    : 1.0 - initial release
// ============================================================================
interface lm_sm_sequencer_if;
    // Request from decode
    logic        start;       // valid LM/SM in decode
    logic        is_store;    // 1 = SM, 0 = LM
    logic [7:0]  reg_mask;    // bit i selects Ri
    logic [15:0] base_addr;   // RA contents, first data address
    logic        hold;        // downstream hazard stall

    // Sequencer status and micro-op stream
    logic        busy;
    logic        stall_fetch;
    logic        uop_valid;
    logic        uop_store;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;
    logic        uop_last;
    logic        done;

    modport master (
        output start, is_store, reg_mask, base_addr, hold,
        input  busy, stall_fetch, uop_valid, uop_store, uop_reg,
               uop_addr, uop_last, done
    );

    modport slave (
        input  start, is_store, reg_mask, base_addr, hold,
        output busy, stall_fetch, uop_valid, uop_store, uop_reg,
               uop_addr, uop_last, done
    );
endinterface
`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lm_sm_sequencer
// Description : Expands one LM/SM instruction into a stream of single-register
//               load/store micro-ops, lowest selected register first, using
//               consecutive data addresses starting at the base address.
//               While micro-ops are in flight the fetch stage is stalled.
// Ports       : clk  - single clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - lm_sm_sequencer_if.slave (request in, micro-ops out)
// Revision    : 1.0 - initial release
// ============================================================================
module lm_sm_sequencer (
    input  wire logic           clk,
    input  wire logic           rst,
    lm_sm_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_mask_rem;
    logic [7:0]  w_mask_nxt;
    logic [15:0] r_addr;
    logic [15:0] w_addr_nxt;
    logic        r_store;
    logic        w_store_nxt;

    logic [2:0]  w_low_idx;
    logic        w_one_left;
    logic        w_uop_valid;

    // Lowest set bit of the remaining mask. Scanning downward lets the
    // lowest index overwrite any higher one.
    always_comb begin
        w_low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask_rem[i]) begin
                w_low_idx = 3'(i);
            end
        end
    end

    // Exactly one bit left: nonzero and clearing the lowest bit leaves zero.
    assign w_one_left = (r_mask_rem != 8'd0) &&
                        ((r_mask_rem & (r_mask_rem - 8'd1)) == 8'd0);

    assign w_uop_valid = (r_state == ST_ISSUE) && !bus.hold;

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask_rem;
        w_addr_nxt  = r_addr;
        w_store_nxt = r_store;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.reg_mask != 8'd0) begin
                        w_mask_nxt  = bus.reg_mask;
                        w_addr_nxt  = bus.base_addr;
                        w_store_nxt = bus.is_store;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        // Empty mask: nothing to issue, just signal completion.
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_uop_valid) begin
                    // Clear the issued (lowest) bit; address wraps at 16 bits.
                    w_mask_nxt = r_mask_rem & (r_mask_rem - 8'd1);
                    w_addr_nxt = r_addr + 16'd1;
                    if (w_one_left) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mask_rem <= 8'd0;
            r_addr     <= 16'd0;
            r_store    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mask_rem <= w_mask_nxt;
            r_addr     <= w_addr_nxt;
            r_store    <= w_store_nxt;
        end
    end

    // Outputs. Stall is released in DONE so the next instruction advances,
    // and is suppressed while reset is asserted.
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.uop_valid   = w_uop_valid;
    assign bus.uop_last    = w_uop_valid && w_one_left;
    assign bus.uop_reg     = w_low_idx;
    assign bus.uop_addr    = r_addr;
    assign bus.uop_store   = r_store;
    assign bus.done        = (r_state == ST_DONE);
    assign bus.stall_fetch = !rst && ((r_state == ST_ISSUE) ||
                                      ((r_state == ST_IDLE) && bus.start));

endmodule
`default_nettype wire
